// File: rtl/simd_lane_sequencer_if.sv
// Request, shared-ALU and commit signals of the SIMD lane sequencer.
// The master modport is the environment (requester plus ALU); the slave modport is the sequencer.
interface simd_lane_sequencer_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
);
    logic                    req_valid;
    logic                    req_ready;
    logic [LANES*LANE_W-1:0] req_srca;
    logic [LANES*LANE_W-1:0] req_srcb;
    logic [3:0]              req_op;
    logic                    req_cond;
    logic [1:0]              req_flagwrite;

    logic                    alu_start;
    logic [3:0]              alu_op;
    logic [LANE_W-1:0]       alu_a;
    logic [LANE_W-1:0]       alu_b;
    logic                    alu_done;
    logic [LANE_W-1:0]       alu_result;
    logic [3:0]              alu_flags;

    logic                    res_valid;
    logic                    res_write;
    logic [LANES*LANE_W-1:0] res_data;
    logic [3:0]              flags_q;

    modport master (
        output req_valid, req_srca, req_srcb, req_op, req_cond, req_flagwrite,
        output alu_done, alu_result, alu_flags,
        input  req_ready, alu_start, alu_op, alu_a, alu_b,
        input  res_valid, res_write, res_data, flags_q
    );

    modport slave (
        input  req_valid, req_srca, req_srcb, req_op, req_cond, req_flagwrite,
        input  alu_done, alu_result, alu_flags,
        output req_ready, alu_start, alu_op, alu_a, alu_b,
        output res_valid, res_write, res_data, flags_q
    );
endinterface

// File: rtl/simd_lane_sequencer.sv
// Serialises a vector op across LANES lanes through one shared single-lane ALU,
// aggregates per-lane flags and commits the vector result and the {N,Z,C,V} register.
module simd_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    simd_lane_sequencer_if.slave bus
);
    localparam int VEC_W = LANES * LANE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    logic [1:0]       state_q;
    logic [IDX_W-1:0] lane_q;
    logic [VEC_W-1:0] srca_q;
    logic [VEC_W-1:0] srcb_q;
    logic [VEC_W-1:0] lanes_q;
    logic [VEC_W-1:0] lanes_next;
    logic [VEC_W-1:0] res_data_q;
    logic [3:0]       op_q;
    logic [1:0]       flagwrite_q;
    logic             cond_ex_q;
    logic             cond_ex;
    logic [3:0]       agg_q;
    logic [3:0]       agg_next;
    logic [3:0]       flags_r;
    logic             last_lane;
    int               lane_base;

    // A conditional op only executes when the architectural Z flag is set.
    assign cond_ex   = !bus.req_cond || flags_r[2];
    assign last_lane = (lane_q == LAST_LANE);
    assign lane_base = int'(lane_q) * LANE_W;

    // Merge the finishing lane into the collected vector and the flag aggregate
    // (N, C, V are ORed across lanes, Z is ANDed so it means "all lanes zero").
    always_comb begin
        lanes_next = lanes_q;
        lanes_next[lane_base +: LANE_W] = bus.alu_result;
        agg_next = {agg_q[3] | bus.alu_flags[3],
                    agg_q[2] & bus.alu_flags[2],
                    agg_q[1] | bus.alu_flags[1],
                    agg_q[0] | bus.alu_flags[0]};
    end

    // Sequencer: accept in IDLE, one ISSUE/WAIT pair per lane, a single COMMIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            lanes_q     <= '0;
            res_data_q  <= '0;
            op_q        <= '0;
            flagwrite_q <= '0;
            cond_ex_q   <= 1'b0;
            agg_q       <= 4'b0100;
            flags_r     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        srca_q      <= bus.req_srca;
                        srcb_q      <= bus.req_srcb;
                        op_q        <= bus.req_op;
                        flagwrite_q <= bus.req_flagwrite;
                        cond_ex_q   <= cond_ex;
                        lane_q      <= '0;
                        agg_q       <= 4'b0100;
                        if (cond_ex) begin
                            state_q <= ISSUE;
                        end else begin
                            res_data_q <= '0;
                            state_q    <= COMMIT;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        lanes_q <= lanes_next;
                        agg_q   <= agg_next;
                        if (last_lane) begin
                            res_data_q <= lanes_next;
                            state_q    <= COMMIT;
                        end else begin
                            lane_q  <= lane_q + 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                COMMIT: begin
                    if (cond_ex_q) begin
                        if (flagwrite_q[1]) flags_r[3:2] <= agg_q[3:2];
                        if (flagwrite_q[0]) flags_r[1:0] <= agg_q[1:0];
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by reset so nothing leaks out during the reset cycle itself.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.alu_start = (state_q == ISSUE) && !reset;
    assign bus.alu_op    = op_q;
    assign bus.alu_a     = srca_q[lane_base +: LANE_W];
    assign bus.alu_b     = srcb_q[lane_base +: LANE_W];
    assign bus.res_valid = (state_q == COMMIT) && !reset;
    assign bus.res_write = bus.res_valid && cond_ex_q;
    assign bus.res_data  = res_data_q;
    assign bus.flags_q   = flags_r;
endmodule
